// File: rtl/vector_io_pkg.sv
// Shared sizing, FSM state and element helpers for the CPU vector output receiver.
// No logic of its own.
package vector_io_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int VECTOR_SIZE = 6;
  localparam int FIFO_DEPTH  = 4;
  localparam int PTR_WIDTH   = 2;
  localparam int IDX_WIDTH   = 3;
  localparam int VEC_WIDTH   = DATA_WIDTH * VECTOR_SIZE;

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [IDX_WIDTH-1:0]  elemIdx_t;
  typedef logic [DATA_WIDTH-1:0] element_t;
  typedef logic [VEC_WIDTH-1:0]  vector_t;

  localparam elemIdx_t LAST_INDEX = elemIdx_t'(VECTOR_SIZE - 1);

  function automatic element_t elementSlice(input vector_t vec, input elemIdx_t k);
    return vec[k*DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/vector_fifo.sv
// Vector-wide FIFO; head is readable combinationally, count/full/empty registered.
// Latency: push visible at head after 1 edge; push while full is only taken with a same-edge pop.
module vector_fifo #(
  parameter int WIDTH     = 96,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     pushData,
  input  logic                 pop,
  output logic [WIDTH-1:0]     popData,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr;
  logic [PTR_WIDTH-1:0] rdPtr;
  logic                 doPush;
  logic                 doPop;

  assign full    = (count == (PTR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + {{PTR_WIDTH{1'b0}}, doPush} - {{PTR_WIDTH{1'b0}}, doPop};
    end
  end

  // Storage is not reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/vector_out_receiver.sv
// Buffers flagged CPU vectors and streams them one element per valid/ready transfer.
// Latency: element 0 valid one edge after capture when idle; never stalls the CPU, overruns set sticky overflow.
module vector_out_receiver
  import vector_io_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorIn,
  input  logic                            vectorValid,
  output logic [DATA_WIDTH-1:0]           elementData,
  output logic [IDX_WIDTH-1:0]            elementIndex,
  output logic                            elementValid,
  input  logic                            elementReady,
  output logic                            lastElement,
  output logic [PTR_WIDTH:0]              fifoCount,
  output logic                            overflow,
  input  logic                            clearOverflow
);

  state_t  state;
  vector_t shiftReg;
  vector_t fifoHead;
  logic    fifoFull;
  logic    fifoEmpty;
  logic    transfer;
  logic    pop;
  logic    push;
  logic    drop;

  assign transfer    = elementValid && elementReady;
  assign lastElement = elementValid && (elementIndex == LAST_INDEX);
  assign pop         = !fifoEmpty && ((state == IDLE) || (transfer && lastElement));
  assign push        = vectorValid && (!fifoFull || pop);
  assign drop        = vectorValid && fifoFull && !pop;
  assign elementData = elementSlice(shiftReg, '0);

  vector_fifo #(
    .WIDTH    (VEC_WIDTH),
    .DEPTH    (FIFO_DEPTH),
    .PTR_WIDTH(PTR_WIDTH)
  ) uFifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pushData(vectorIn),
    .pop     (pop),
    .popData (fifoHead),
    .count   (fifoCount),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shiftReg     <= '0;
      elementIndex <= '0;
      elementValid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // A drop on the same edge as a clear wins, so no overrun goes unreported.
      overflow <= drop || (overflow && !clearOverflow);

      case (state)
        IDLE: begin
          if (pop) begin
            shiftReg     <= fifoHead;
            elementIndex <= '0;
            elementValid <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (transfer) begin
            if (lastElement) begin
              if (pop) begin
                shiftReg     <= fifoHead;
                elementIndex <= '0;
              end else begin
                elementValid <= 1'b0;
                state        <= IDLE;
              end
            end else begin
              shiftReg     <= shiftReg >> DATA_WIDTH;
              elementIndex <= elementIndex + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
